// File: rtl/banked_spram_pkg.sv
// Shared types and constants for the banked SPRAM window.
package banked_spram_pkg;

  typedef enum logic {StClear, StIdle} state_e;

  // SB_SPRAM256KA is 16K x 16
  localparam int unsigned SpramAw = 14;

  localparam logic [15:0] DefaultBase        = 16'hC000;
  localparam logic [15:0] DefaultBankRegAddr = 16'hFF70;

endpackage

// File: rtl/banked_spram_core.sv
// Single-port 16K x 16 RAM with nibble write mask, shaped like SB_SPRAM256KA.
// Under SYNTHESIS the iCE40 primitive is instantiated; otherwise a behavioural
// model with the same synchronous read/write timing is used.
module banked_spram_core
  import banked_spram_pkg::*;
(
  input  logic               clk_i,
  input  logic [SpramAw-1:0] addr_i,
  input  logic [15:0]        wdata_i,
  input  logic [3:0]         maskwren_i,
  input  logic               wren_i,
  output logic [15:0]        rdata_o
);

`ifdef SYNTHESIS
  SB_SPRAM256KA u_spram (
    .ADDRESS   (addr_i),
    .DATAIN    (wdata_i),
    .MASKWREN  (maskwren_i),
    .WREN      (wren_i),
    .CHIPSELECT(1'b1),
    .CLOCK     (clk_i),
    .STANDBY   (1'b0),
    .SLEEP     (1'b0),
    .POWEROFF  (1'b1),
    .DATAOUT   (rdata_o)
  );
`else
  localparam int unsigned Words = 1 << SpramAw;

  logic [15:0] mem_q [Words];
  logic [15:0] rdata_q;
  logic [15:0] bit_mask;

  // Expand the nibble write mask to a bit mask
  always_comb begin
    bit_mask = {{4{maskwren_i[3]}}, {4{maskwren_i[2]}},
                {4{maskwren_i[1]}}, {4{maskwren_i[0]}}};
  end

  // Masked write, or registered read when not writing
  always_ff @(posedge clk_i) begin
    if (wren_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/banked_spram.sv
// Banked byte-wide RAM window on a 16-bit CPU bus, backed by one 16-bit SPRAM.
// Bank 0 is fixed at BASE, the next BANK_SIZE bytes show the bank chosen by the
// bank-select register. After reset the whole SPRAM is zeroed, one word per cycle.
// Optional: define BANKED_SPRAM_ECHO_EN to mirror the two windows into
// [BASE+2*BANK_SIZE, 16'hFE00).
module banked_spram
  import banked_spram_pkg::*;
#(
  parameter logic [15:0] BASE          = DefaultBase,
  parameter logic [15:0] BANK_SIZE     = 16'h1000,
  parameter int unsigned NUM_BANKS     = 8,
  parameter logic [15:0] BANK_REG_ADDR = DefaultBankRegAddr
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] abs_addr,
  input  logic [7:0]  data_w,
  input  logic        write_enable,
  output logic [7:0]  data_r,
  output logic        data_active,
  output logic        read_valid,
  output logic        busy
);

  localparam int unsigned SelW      = $clog2(NUM_BANKS);
  localparam int unsigned BankShift = $clog2(BANK_SIZE);
  localparam logic [16:0] Base17    = {1'b0, BASE};
  localparam logic [16:0] Size17    = {1'b0, BANK_SIZE};
  localparam logic [16:0] WinEnd    = Base17 + (Size17 << 1);

  state_e             state_q, state_d;
  logic [SpramAw-1:0] clr_cnt_q, clr_cnt_d;
  logic [SelW-1:0]    bank_sel_q, bank_sel_d;
  logic               rd_valid_q, rd_reg_q, rd_lane_q;
  logic [7:0]         data_q;

  logic [16:0]        eff_addr;
  logic               fixed_hit, sw_hit, ram_hit, reg_hit;
  logic [14:0]        bank_base, linear;
  logic [SpramAw-1:0] word_addr;
  logic               lane;
  logic               ram_we, reg_we;

  logic [SpramAw-1:0] core_addr;
  logic [15:0]        core_wdata, core_rdata;
  logic [3:0]         core_mask;
  logic               core_wren;

  // Address decode: window hits and linear byte address within the SPRAM
  always_comb begin
    eff_addr = {1'b0, abs_addr};
`ifdef BANKED_SPRAM_ECHO_EN
    if (eff_addr >= WinEnd && eff_addr < 17'h0FE00) begin
      eff_addr = eff_addr - (Size17 << 1);
    end
`endif
    fixed_hit = (eff_addr >= Base17) && (eff_addr < Base17 + Size17);
    sw_hit    = (eff_addr >= Base17 + Size17) && (eff_addr < WinEnd);
    ram_hit   = fixed_hit || sw_hit;
    reg_hit   = (abs_addr == BANK_REG_ADDR);
    bank_base = sw_hit ? (15'(bank_sel_q) << BankShift) : '0;
    // BANK_SIZE is a power of two, so masking the window offset strips the bank part
    linear    = bank_base + 15'((eff_addr - Base17) & (Size17 - 17'd1));
    word_addr = linear[14:1];
    lane      = linear[0];
  end

  // Bus qualification: nothing is claimed or written while clearing
  always_comb begin
    busy        = (state_q == StClear);
    data_active = (ram_hit || reg_hit) && !write_enable && !busy;
    ram_we      = ram_hit && write_enable && !busy;
    reg_we      = reg_hit && write_enable && !busy;
  end

  // Clear FSM next state: walk every word once, then idle
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr_cnt_q == '1) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StIdle:  ;
      default: state_d = StClear;
    endcase
  end

  // Bank register next value: modulo bank count, bank 0 never selectable
  always_comb begin
    bank_sel_d = bank_sel_q;
    if (reg_we) begin
      bank_sel_d = SelW'(data_w % 8'(NUM_BANKS));
      if (bank_sel_d == '0) begin
        bank_sel_d = SelW'(1);
      end
    end
  end

  // SPRAM port mux: clear engine owns the RAM while busy
  always_comb begin
    if (busy) begin
      core_addr  = clr_cnt_q;
      core_wdata = 16'h0000;
      core_mask  = 4'b1111;
      core_wren  = 1'b1;
    end else begin
      core_addr  = word_addr;
      core_wdata = {data_w, data_w};
      core_mask  = lane ? 4'b1100 : 4'b0011;
      core_wren  = ram_we;
    end
  end

  // State, bank register and read pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      bank_sel_q <= SelW'(1);
      rd_valid_q <= 1'b0;
      rd_reg_q   <= 1'b0;
      rd_lane_q  <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      bank_sel_q <= bank_sel_d;
      rd_valid_q <= data_active;
      rd_reg_q   <= reg_hit;
      rd_lane_q  <= lane;
      data_q     <= data_r;
    end
  end

  // Read data: fresh byte on read_valid, otherwise hold the last value.
  // bank_sel_q cannot change between a register read and its result cycle.
  always_comb begin
    if (!rd_valid_q) begin
      data_r = data_q;
    end else if (rd_reg_q) begin
      data_r = {{(8 - SelW){1'b1}}, bank_sel_q};
    end else begin
      data_r = rd_lane_q ? core_rdata[15:8] : core_rdata[7:0];
    end
  end

  assign read_valid = rd_valid_q;

  banked_spram_core u_core (
    .clk_i     (clk),
    .addr_i    (core_addr),
    .wdata_i   (core_wdata),
    .maskwren_i(core_mask),
    .wren_i    (core_wren),
    .rdata_o   (core_rdata)
  );

endmodule

// File: tb/tb_banked_spram.sv
// Directed, table-driven bench for banked_spram (default parameters).
module tb_banked_spram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] abs_addr = 16'h0000;
  logic [7:0]  data_w = 8'h00;
  logic        write_enable = 1'b0;
  logic [7:0]  data_r;
  logic        data_active;
  logic        read_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  banked_spram dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abs_addr    (abs_addr),
    .data_w      (data_w),
    .write_enable(write_enable),
    .data_r      (data_r),
    .data_active (data_active),
    .read_valid  (read_valid),
    .busy        (busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        exp_act;
    logic [7:0]  exp_data;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] a, input logic we, input logic [7:0] d,
                              input logic act, input logic [7:0] e, input string n);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = d; v.exp_act = act; v.exp_data = e; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    abs_addr = a; data_w = d; write_enable = 1'b1;
    #1 check("write_unclaimed", 32'(data_active), 32'd0);
    @(negedge clk);
    write_enable = 1'b0; abs_addr = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic act, input logic [7:0] e,
                          input string name);
    @(negedge clk);
    abs_addr = a; write_enable = 1'b0;
    #1 check({name, "_active"}, 32'(data_active), 32'(act));
    @(posedge clk);
    #1 check({name, "_rvalid"}, 32'(read_valid), 32'(act));
    if (act) check({name, "_data"}, 32'(data_r), 32'(e));
    abs_addr = 16'h0000;
  endtask

  initial begin
    int n;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rvalid", 32'(read_valid), 32'd0);
    check("rst_data_r", 32'(data_r), 32'h00);
    repeat (3) @(negedge clk);

    // First clear, interrupted by reset after 100 cycles
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) @(negedge clk);
    check("midclear_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check("midclear_rst_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);

    // Full clear; stray bus writes while busy must be dropped
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 20000) begin
      n++;
      if (n == 5) begin
        abs_addr = 16'hC000; data_w = 8'hA5; write_enable = 1'b1;
      end else if (n == 6) begin
        abs_addr = 16'hFF70; data_w = 8'h05; write_enable = 1'b1;
      end else if (n == 7) begin
        abs_addr = 16'hC000; write_enable = 1'b0;
        #1 check("busy_read_unclaimed", 32'(data_active), 32'd0);
      end else begin
        abs_addr = 16'h0000; write_enable = 1'b0;
      end
      @(negedge clk);
    end
    abs_addr = 16'h0000; write_enable = 1'b0;
    check("busy_cycles", 32'(n), 32'd16384);

    // Directed vectors
    vecs.push_back(mk(16'hC000, 1'b0, 8'h00, 1'b1, 8'h00, "c000_cleared"));
    vecs.push_back(mk(16'hC123, 1'b0, 8'h00, 1'b1, 8'h00, "c123_cleared"));
    vecs.push_back(mk(16'hFF70, 1'b0, 8'h00, 1'b1, 8'hF9, "bank_default"));
    vecs.push_back(mk(16'hC000, 1'b1, 8'hA5, 1'b0, 8'h00, "w_c000"));
    vecs.push_back(mk(16'hC001, 1'b1, 8'h5A, 1'b0, 8'h00, "w_c001"));
    vecs.push_back(mk(16'hC000, 1'b0, 8'h00, 1'b1, 8'hA5, "r_c000_low"));
    vecs.push_back(mk(16'hC001, 1'b0, 8'h00, 1'b1, 8'h5A, "r_c001_high"));
    vecs.push_back(mk(16'hFF70, 1'b1, 8'h03, 1'b0, 8'h00, "sel3"));
    vecs.push_back(mk(16'hD000, 1'b1, 8'h11, 1'b0, 8'h00, "w_b3"));
    vecs.push_back(mk(16'hFF70, 1'b1, 8'h05, 1'b0, 8'h00, "sel5"));
    vecs.push_back(mk(16'hD000, 1'b1, 8'h22, 1'b0, 8'h00, "w_b5"));
    vecs.push_back(mk(16'hFF70, 1'b0, 8'h00, 1'b1, 8'hFD, "bank_reg5"));
    vecs.push_back(mk(16'hFF70, 1'b1, 8'h03, 1'b0, 8'h00, "sel3b"));
    vecs.push_back(mk(16'hD000, 1'b0, 8'h00, 1'b1, 8'h11, "r_b3"));
    vecs.push_back(mk(16'hFF70, 1'b0, 8'h00, 1'b1, 8'hFB, "bank_reg3"));
    vecs.push_back(mk(16'hFF70, 1'b1, 8'h05, 1'b0, 8'h00, "sel5b"));
    vecs.push_back(mk(16'hD000, 1'b0, 8'h00, 1'b1, 8'h22, "r_b5"));
    vecs.push_back(mk(16'hFF70, 1'b1, 8'h00, 1'b0, 8'h00, "sel0"));
    vecs.push_back(mk(16'hFF70, 1'b0, 8'h00, 1'b1, 8'hF9, "sel0_is1"));
    vecs.push_back(mk(16'hD000, 1'b0, 8'h00, 1'b1, 8'h00, "r_b1_empty"));
    vecs.push_back(mk(16'hFF70, 1'b1, 8'h0B, 1'b0, 8'h00, "sel11"));
    vecs.push_back(mk(16'hFF70, 1'b0, 8'h00, 1'b1, 8'hFB, "sel11_mod"));
    vecs.push_back(mk(16'hD000, 1'b0, 8'h00, 1'b1, 8'h11, "r_b3_again"));
    vecs.push_back(mk(16'hFF70, 1'b1, 8'h08, 1'b0, 8'h00, "sel8"));
    vecs.push_back(mk(16'hFF70, 1'b0, 8'h00, 1'b1, 8'hF9, "sel8_is1"));
    vecs.push_back(mk(16'hD001, 1'b1, 8'h3C, 1'b0, 8'h00, "w_b1_hi"));
    vecs.push_back(mk(16'hD001, 1'b0, 8'h00, 1'b1, 8'h3C, "r_b1_hi"));
    vecs.push_back(mk(16'hC000, 1'b0, 8'h00, 1'b1, 8'hA5, "fixed_kept"));
    vecs.push_back(mk(16'h1000, 1'b1, 8'hFF, 1'b0, 8'h00, "w_outside"));
    vecs.push_back(mk(16'hC000, 1'b0, 8'h00, 1'b1, 8'hA5, "outside_no_write"));
    vecs.push_back(mk(16'h1234, 1'b0, 8'h00, 1'b0, 8'h00, "r_1234"));
    vecs.push_back(mk(16'hBFFF, 1'b0, 8'h00, 1'b0, 8'h00, "r_bfff"));
    vecs.push_back(mk(16'hFF71, 1'b0, 8'h00, 1'b0, 8'h00, "r_ff71"));
`ifdef BANKED_SPRAM_ECHO_EN
    vecs.push_back(mk(16'hE010, 1'b1, 8'h77, 1'b0, 8'h00, "w_echo"));
    vecs.push_back(mk(16'hC010, 1'b0, 8'h00, 1'b1, 8'h77, "r_echo_alias"));
    vecs.push_back(mk(16'hFF70, 1'b1, 8'h03, 1'b0, 8'h00, "sel3_echo"));
    vecs.push_back(mk(16'hF000, 1'b0, 8'h00, 1'b1, 8'h11, "r_echo_bank"));
`else
    vecs.push_back(mk(16'hE010, 1'b0, 8'h00, 1'b0, 8'h00, "r_e010_unclaimed"));
    vecs.push_back(mk(16'hF000, 1'b0, 8'h00, 1'b0, 8'h00, "r_f000_unclaimed"));
`endif

    foreach (vecs[i]) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
      else bus_read(vecs[i].addr, vecs[i].exp_act, vecs[i].exp_data, vecs[i].name);
    end

    // Bank register write is visible to a read in the very next cycle
    bus_write(16'hFF70, 8'h05);
    @(negedge clk);
    abs_addr = 16'hFF70; data_w = 8'h03; write_enable = 1'b1;
    @(negedge clk);
    abs_addr = 16'hD000; write_enable = 1'b0;
    #1 check("b2b_active", 32'(data_active), 32'd1);
    @(posedge clk);
    #1 check("b2b_bank_data", 32'(data_r), 32'h11);

    // Back-to-back reads with lane tracking, then hold when idle
    @(negedge clk);
    abs_addr = 16'hC000;
    @(posedge clk);
    #1 check("pipe0_data", 32'(data_r), 32'hA5);
    @(negedge clk);
    abs_addr = 16'hC001;
    @(posedge clk);
    #1 check("pipe1_rvalid", 32'(read_valid), 32'd1);
    check("pipe1_data", 32'(data_r), 32'h5A);
    @(negedge clk);
    abs_addr = 16'h0000;
    @(posedge clk);
    #1 check("hold_rvalid", 32'(read_valid), 32'd0);
    check("hold_data", 32'(data_r), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banked_spram.md
BANKED_SPRAM -- requirements
Module: banked_spram

Interface
REQ-001 Parameter BASE, default 16'hC000, start of the fixed-bank window.
REQ-002 Parameter BANK_SIZE, default 16'h1000, bytes per bank; power of two.
REQ-003 Parameter NUM_BANKS, default 8, total banks including fixed bank 0; NUM_BANKS*BANK_SIZE <= 32768.
REQ-004 Parameter BANK_REG_ADDR, default 16'hFF70, absolute address of the bank-select register.
REQ-005 Port clk, input, 1, the single clock; all state changes on rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port abs_addr, input, 16, absolute CPU bus address.
REQ-008 Port data_w, input, 8, write data.
REQ-009 Port write_enable, input, 1, bus write strobe for the current cycle.
REQ-010 Port data_r, output, 8, registered read data.
REQ-011 Port data_active, output, 1, combinational: this block claims the current read.
REQ-012 Port read_valid, output, 1, data_r holds the result of the read claimed on the previous cycle.
REQ-013 Port busy, output, 1, high while the post-reset clear runs.

Function
REQ-014 Window: fixed region [BASE, BASE+BANK_SIZE) maps to bank 0; switchable region [BASE+BANK_SIZE, BASE+2*BANK_SIZE) maps to bank_sel.
REQ-015 Linear byte address = bank*BANK_SIZE + offset; SPRAM word address = linear[14:1]; byte lane = linear[0] (0 = low byte, 1 = high byte).
REQ-016 Writes use MASKWREN to touch only the selected byte lane; the other byte of the word is preserved.
REQ-017 bank_sel register, width clog2(NUM_BANKS); write of value v at BANK_REG_ADDR stores v mod NUM_BANKS; stored 0 is stored as 1.
REQ-018 Bank register write takes effect from the next cycle.
REQ-019 Read of BANK_REG_ADDR is claimed: data_r = all upper bits 1, low bits = bank_sel (default 8'hF9 after reset).
REQ-020 data_active = hit && !write_enable && !busy, combinational in the same cycle as the address.
REQ-021 Read latency exactly 1 cycle: read_valid pulses the cycle after data_active, data_r then holds the lane-selected byte (lane registered with the request).
REQ-022 data_r holds its last value when read_valid is low.
REQ-023 Addresses outside all windows: no write, data_active 0, read_valid 0 next cycle.
REQ-024 FSM states CLEAR and IDLE; CLEAR writes 16'h0000 to word counter 0..16383, one word per cycle, both lanes, then enters IDLE after word 16383.
REQ-025 In CLEAR: busy 1, bus writes to RAM and bank register dropped, reads unclaimed.
REQ-026 In IDLE: busy 0, clear counter static.

Reset
REQ-027 On rst_n low: FSM = CLEAR, clear counter 0, bank_sel 1, data_r 8'h00, read_valid 0, busy 1.
REQ-028 Reset asserted mid-clear or mid-operation restarts the clear from word 0; RAM contents otherwise undefined until clear completes.

Configuration
REQ-029 Macro BANKED_SPRAM_ECHO_EN defined: addresses [BASE+2*BANK_SIZE, 16'hFE00) alias [BASE, BASE+(16'hFE00-BASE-2*BANK_SIZE)) for reads and writes, including bank switching.
REQ-030 Macro undefined: echo range unclaimed, treated as out-of-window per REQ-023.

Structure
REQ-031 Shared package holds FSM state enum, SPRAM word-address width (14) and default BASE/BANK_REG_ADDR constants.
REQ-032 One sub-module, banked_spram_core, wraps SB_SPRAM256KA (address, 16-bit data, lane mask, wren); decode, FSM and bank register live in banked_spram.

Verification
REQ-033 Reset release -> busy high for exactly 16384 cycles, then low; read of 16'hC123 afterward returns 8'h00.
REQ-034 Write 8'hA5 to 16'hC000, 8'h5A to 16'hC001; read both -> 8'hA5 then 8'h5A, each with read_valid one cycle after data_active.
REQ-035 Write 8'h03 to 16'hFF70, write 8'h11 to 16'hD000; write 8'h05 to FF70, write 8'h22 to D000; select bank 3 -> D000 reads 8'h11, bank 5 -> 8'h22.
REQ-036 Write 8'h00 to 16'hFF70 -> read FF70 returns 8'hF9.
REQ-037 With BANKED_SPRAM_ECHO_EN: write 8'h77 to 16'hE010 -> read 16'hC010 returns 8'h77; without it, read 16'hE010 -> data_active 0.
REQ-038 Write to 16'hC000 while busy, reset mid-clear at cycle 100 -> busy high 16384 cycles after release, C000 reads 8'h00.
